// File: rtl/fetch_queue_pkg.sv
// Shared types and default sizing for the Fetch -> Decode prefetch queue.
// The {pc, inst} entry layout keeps the PC in the upper bits.
package fetch_queue_pkg;

  localparam int INST_W_DEF = 32;
  localparam int ADDR_W_DEF = 16;
  localparam int FQ_DEPTH   = 4;

  typedef logic [INST_W_DEF-1:0] inst_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef struct packed {
    addr_t pc;
    inst_t ins;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ptr.sv
// Wrap-around queue pointer: increments modulo 2**W, with a synchronous clear that wins over increment.
module fq_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignment; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between Fetch and Decode: {pc, inst} FIFO with flush on taken
// branch, sticky halt that blocks new entries, and optional zero-latency bypass when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = FQ_DEPTH,
  parameter int BYPASS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [INST_W-1:0]          push_inst,
  input  logic [ADDR_W-1:0]          push_pc,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [INST_W-1:0]          pop_inst,
  output logic [ADDR_W-1:0]          pop_pc,
  input  logic                       flush,
  input  logic                       halt,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] ins;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count_q, count_d;
  logic            halted_q, halted_d;
  logic            empty, full, byp_avail;
  logic            push_fire, pop_fire, pass_thru, wr_en, rd_en;
  entry_t          head;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    // rst gating keeps both handshakes low for the whole time reset is held.
    push_ready = rst && !full && !halted_q && !flush;
    byp_avail  = (BYPASS != 0) && empty && push_valid && push_ready;
    pop_valid  = rst && !flush && (!empty || byp_avail);

    push_fire  = push_valid && push_ready;
    pop_fire   = pop_valid && pop_ready;
    pass_thru  = byp_avail && pop_ready;
    wr_en      = push_fire && !pass_thru;
    rd_en      = pop_fire && !pass_thru;

    count_d    = flush ? '0 : count_q + CW'(wr_en) - CW'(rd_en);
    halted_d   = halted_q || halt;

    head = '0;
    if (!empty) begin
      head = mem_q[rd_ptr];
    end else if (byp_avail) begin
      head = '{pc: push_pc, ins: push_inst};
    end
  end

  assign pop_pc   = head.pc;
  assign pop_inst = head.ins;
  assign count    = count_q;
  assign halted   = halted_q;

  fq_ptr #(.W(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_en),
    .clr (flush),
    .ptr (wr_ptr)
  );

  fq_ptr #(.W(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_en),
    .clr (flush),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= '{pc: push_pc, ins: push_inst};
    end
  end

endmodule
